// File: rtl/bus_seq_master.sv
// Table-driven bus master: on a debounced trigger it walks ADDR_TABLE issuing writes, reads or
// write-then-verify transactions, with split support, a per-transaction timeout and pass/fail counters.
module bus_seq_master #(
    parameter int unsigned               NUM_ENTRIES  = 4,
    parameter logic [NUM_ENTRIES*16-1:0] ADDR_TABLE   = '0,
    parameter logic [7:0]                DATA_SEED    = 8'h7A,
    parameter int unsigned               DEBOUNCE_CYC = 50000,
    parameter int unsigned               TIMEOUT_CYC  = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_trigger,
    input  logic [1:0]  mode,
    input  logic        m_grant,
    input  logic        m_ack,
    input  logic        m_split_ack,
    input  logic [7:0]  m_data_in,
    input  logic        m_data_in_valid,
    output logic        m_req,
    output logic [15:0] m_address_out,
    output logic        m_address_out_valid,
    output logic [7:0]  m_data_out,
    output logic        m_data_out_valid,
    output logic        m_rw,
    output logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  last_rd_data,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic        err_timeout
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, ADDR, WDATA, WWAIT, RWAIT, CHECK, NEXT, DONE
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Trigger synchroniser, debouncer and rising-edge start pulse
    logic             sync1_q, sync2_q, deb_q, start_q;
    logic [DEB_W-1:0] deb_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            start_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= btn_trigger;
            sync2_q <= sync1_q;
            start_q <= 1'b0;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q >= DEB_LAST) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
                start_q   <= sync2_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             launch, tmo_hit;
    logic             req_d, addr_vld_d, data_vld_d, rw_d, ready_d, busy_d, done_d, err_d;
    logic [15:0]      addr_d;
    logic [7:0]       data_d, last_rd_d, pass_d, fail_d;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        tmo_d      = tmo_q;
        launch     = 1'b0;
        req_d      = m_req;
        addr_d     = m_address_out;
        addr_vld_d = 1'b0;
        data_d     = m_data_out;
        data_vld_d = 1'b0;
        rw_d       = m_rw;
        ready_d    = m_ready;
        done_d     = 1'b0;
        last_rd_d  = last_rd_data;
        pass_d     = pass_cnt;
        fail_d     = fail_cnt;
        err_d      = err_timeout;
        tmo_hit    = (tmo_q >= TMO_LAST);

        unique case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = REQ;
                    mode_d  = mode;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (m_req && m_grant) begin
                    state_d    = ADDR;
                    addr_vld_d = 1'b1;
                    tmo_d      = '0;
                end
            end
            ADDR: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (m_rw) begin
                    state_d    = WDATA;
                    data_vld_d = 1'b1;
                end else begin
                    state_d = RWAIT;
                    ready_d = 1'b1;
                end
            end
            WDATA: begin
                tmo_d   = tmo_q + TMO_W'(1);
                state_d = WWAIT;
            end
            WWAIT: begin
                if (m_split_ack) req_d = 1'b0;
                if (m_ack) begin
                    req_d = 1'b0;
                    if (mode_q[1]) begin
                        // Verify modes re-arbitrate for the read-back of the same address
                        state_d = REQ;
                        rw_d    = 1'b0;
                    end else begin
                        state_d = CHECK;
                    end
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    fail_d  = sat_inc(fail_cnt);
                    state_d = NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RWAIT: begin
                if (m_split_ack) req_d = 1'b0;
                if (m_data_in_valid) begin
                    last_rd_d = m_data_in;
                    req_d     = 1'b0;
                    ready_d   = 1'b0;
                    state_d   = CHECK;
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    ready_d = 1'b0;
                    err_d   = 1'b1;
                    fail_d  = sat_inc(fail_cnt);
                    state_d = NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                state_d = NEXT;
                if (mode_q[1] && (last_rd_data != DATA_SEED + 8'(idx_q))) begin
                    fail_d = sat_inc(fail_cnt);
                end else begin
                    pass_d = sat_inc(pass_cnt);
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            DONE: begin
                if (mode_q == 2'd3) begin
                    idx_d   = '0;
                    state_d = REQ;
                    launch  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New entry: present address, write data and direction for the whole request
        if (launch) begin
            req_d  = 1'b1;
            addr_d = ADDR_TABLE[{idx_d, 4'b0000} +: 16];
            data_d = DATA_SEED + 8'(idx_d);
            rw_d   = (mode_d != 2'd1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            idx_q               <= '0;
            mode_q              <= '0;
            tmo_q               <= '0;
            m_req               <= 1'b0;
            m_address_out       <= '0;
            m_address_out_valid <= 1'b0;
            m_data_out          <= '0;
            m_data_out_valid    <= 1'b0;
            m_rw                <= 1'b0;
            m_ready             <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            last_rd_data        <= '0;
            pass_cnt            <= '0;
            fail_cnt            <= '0;
            err_timeout         <= 1'b0;
        end else begin
            state_q             <= state_d;
            idx_q               <= idx_d;
            mode_q              <= mode_d;
            tmo_q               <= tmo_d;
            m_req               <= req_d;
            m_address_out       <= addr_d;
            m_address_out_valid <= addr_vld_d;
            m_data_out          <= data_d;
            m_data_out_valid    <= data_vld_d;
            m_rw                <= rw_d;
            m_ready             <= ready_d;
            busy                <= busy_d;
            done                <= done_d;
            last_rd_data        <= last_rd_d;
            pass_cnt            <= pass_d;
            fail_cnt            <= fail_d;
            err_timeout         <= err_d;
        end
    end

endmodule
